// File: rtl/dmem_wait.sv
// ============================================================================
// Module   : dmem_wait
// Purpose  : Data memory behind the MEM stage of the pipelined MIPS core.
//            Byte/half/word loads and stores with little-endian lanes,
//            signed/unsigned load extension, a programmable number of wait
//            cycles per access, and error reporting for misaligned or
//            out-of-range accesses. The pipeline stalls while ready=0 and
//            resumes on the single-cycle done pulse.
// Ports    : clk      - clock, all state updates on posedge
//            reset_n  - asynchronous active-low reset
//            req      - access request, sampled when ready=1
//            we       - 1=store, 0=load
//            size     - 00 byte, 01 half, 10 word, 11 illegal
//            sgn      - sign-extend (1) / zero-extend (0) byte/half loads
//            a        - byte address
//            wd       - store data, right-aligned
//            ready    - high in IDLE, request may be accepted
//            done     - one-cycle completion pulse
//            err      - valid with done, access rejected
//            rd       - load result, held until the next done
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_wait #(
  parameter int    DEPTH     = 64,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rd
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [3:0]  LAT_W   = 4'(LATENCY);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state, state_nx;

  logic [31:0] mem [DEPTH];

  // Captured request; the access is performed from these, so the pipeline
  // may change the inputs freely once the request has been accepted.
  logic [3:0]  cnt;
  logic [31:0] a_q;
  logic [31:0] wd_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        sgn_q;

  logic          access;
  logic          misaligned;
  logic          out_of_range;
  logic          acc_err;
  logic [AW-1:0] idx;
  logic [31:0]   word_rd;
  logic [31:0]   lane_word;
  logic [31:0]   load_val;
  logic [31:0]   wd_lane;
  logic [3:0]    be;

  // Byte enables for a given size and low address bits. Illegal size yields
  // no enabled lanes.
  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] lo);
    logic [3:0] m;
    m = 4'b0000;
    case (sz)
      2'b00:   m = 4'b0001 << lo;
      2'b01:   m = lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = BUSY;
      BUSY:    if (cnt == 4'd0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign ready  = (state == IDLE);
  assign access = (state == BUSY) && (cnt == 4'd0);

  // --------------------------------------------------------------------------
  // Access decode on the captured request
  // --------------------------------------------------------------------------
  assign misaligned   = (size_q == 2'b11) ||
                        ((size_q == 2'b01) && a_q[0]) ||
                        ((size_q == 2'b10) && (a_q[1:0] != 2'b00));
  assign out_of_range = ({2'b00, a_q[31:2]} >= DEPTH_W);
  assign acc_err      = misaligned || out_of_range;
  assign idx          = a_q[AW+1:2];
  assign word_rd      = mem[idx];
  assign be           = lane_be(size_q, a_q[1:0]);

  // Replicate the right-aligned store data into every lane so the byte
  // enables alone select where it lands.
  always_comb begin
    wd_lane = wd_q;
    case (size_q)
      2'b00:   wd_lane = {4{wd_q[7:0]}};
      2'b01:   wd_lane = {2{wd_q[15:0]}};
      default: wd_lane = wd_q;
    endcase
  end

  always_comb begin
    lane_word = word_rd >> {a_q[1:0], 3'b000};
    load_val  = word_rd;
    case (size_q)
      2'b00:   load_val = sgn_q ? {{24{lane_word[7]}}, lane_word[7:0]}
                                : {24'h000000, lane_word[7:0]};
      2'b01:   load_val = sgn_q ? {{16{lane_word[15]}}, lane_word[15:0]}
                                : {16'h0000, lane_word[15:0]};
      default: load_val = word_rd;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control / result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= 4'd0;
      done   <= 1'b0;
      err    <= 1'b0;
      rd     <= 32'h0;
      a_q    <= 32'h0;
      wd_q   <= 32'h0;
      we_q   <= 1'b0;
      size_q <= 2'b00;
      sgn_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (ready && req) begin
        a_q    <= a;
        wd_q   <= wd;
        we_q   <= we;
        size_q <= size;
        sgn_q  <= sgn;
        cnt    <= LAT_W;
      end else if (state == BUSY) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          done <= 1'b1;
          err  <= acc_err;
          // Stores leave rd alone so it keeps the last load result.
          if (acc_err)    rd <= 32'h0;
          else if (!we_q) rd <= load_val;
        end
      end
    end
  end

  // Memory array is deliberately not reset. A reset mid-access forces IDLE,
  // which removes the access strobe, so an abandoned store never writes.
  always_ff @(posedge clk) begin
    if (access && we_q && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd_lane[8*i +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Input sanity checks on accepted requests
  // --------------------------------------------------------------------------
  logic [3:0]  in_be;
  logic [31:0] in_mask;

  assign in_be   = lane_be(size, a[1:0]);
  assign in_mask = {{8{in_be[3]}}, {8{in_be[2]}}, {8{in_be[1]}}, {8{in_be[0]}}};

  a_req_known: assert property (@(posedge clk) disable iff (!reset_n)
    (ready && req) |-> !$isunknown({a, we, size}))
    else $error("dmem_wait: unknown a/we/size on accepted request");

  a_wd_known: assert property (@(posedge clk) disable iff (!reset_n)
    (ready && req && we) |-> !$isunknown(wd & in_mask))
    else $error("dmem_wait: unknown store data in active lanes");

endmodule

`default_nettype wire

// File: tb/tb_dmem_wait.sv
// ============================================================================
// Module   : tb_dmem_wait
// Purpose  : Self-checking bench for dmem_wait. A LATENCY=1 instance is
//            exercised from a vector table plus a reset-during-access
//            sequence; LATENCY=0 and LATENCY=15 instances check back-to-back
//            throughput and that requests during BUSY are ignored.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_wait;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req, we, sgn;
  logic [1:0]  size;
  logic [31:0] a, wd;
  logic        ready, done, err;
  logic [31:0] rd;

  // Throughput instances: word loads from address 0
  logic        req_l0, req_l15;
  logic        ld_we   = 1'b0;
  logic        ld_sgn  = 1'b0;
  logic [1:0]  ld_size = 2'b10;
  logic [31:0] ld_a    = 32'h0;
  logic [31:0] ld_wd   = 32'h0;
  logic        rdy_l0, done_l0, err_l0;
  logic        rdy_l15, done_l15, err_l15;
  logic [31:0] rd_l0, rd_l15;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_wait #(.DEPTH(64), .LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .size(size), .sgn(sgn),
    .a(a), .wd(wd), .ready(ready), .done(done), .err(err), .rd(rd)
  );

  dmem_wait #(.DEPTH(64), .LATENCY(0)) dut_l0 (
    .clk(clk), .reset_n(reset_n), .req(req_l0), .we(ld_we), .size(ld_size), .sgn(ld_sgn),
    .a(ld_a), .wd(ld_wd), .ready(rdy_l0), .done(done_l0), .err(err_l0), .rd(rd_l0)
  );

  dmem_wait #(.DEPTH(64), .LATENCY(15)) dut_l15 (
    .clk(clk), .reset_n(reset_n), .req(req_l15), .we(ld_we), .size(ld_size), .sgn(ld_sgn),
    .a(ld_a), .wd(ld_wd), .ready(rdy_l15), .done(done_l15), .err(err_l15), .rd(rd_l15)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] wd;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic s,
                              input logic [31:0] ad, input logic [31:0] d,
                              input logic e, input logic [31:0] r);
    vec_t v;
    v.we = w; v.size = sz; v.sgn = s; v.a = ad; v.wd = d; v.exp_err = e; v.exp_rd = r;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One access on the LATENCY=1 instance. Called at a negedge; returns at the
  // negedge after the done pulse, which is again an IDLE cycle.
  task automatic do_access(input string name, input vec_t v);
    int idx;
    idx = 0;
    while (!ready && idx < 40) begin
      @(negedge clk);
      idx++;
    end
    chk({name, "_ready"}, 32'(ready), 32'd1);
    req = 1'b1; we = v.we; size = v.size; sgn = v.sgn; a = v.a; wd = v.wd;
    @(negedge clk);                 // first sample after the accept edge
    req = 1'b0; a = 32'hFFFF_FFFF; wd = 32'h0; we = 1'b0; size = 2'b10; sgn = 1'b0;
    idx = 0;
    while (!done && idx < 40) begin
      @(negedge clk);
      idx++;
    end
    chk({name, "_latency"}, 32'(idx), 32'd2);
    chk({name, "_err"}, 32'(err), 32'(v.exp_err));
    chk({name, "_rd"}, rd, v.exp_rd);
    @(negedge clk);
    chk({name, "_pulse"}, {30'h0, done, err}, 32'h0);
  endtask

  // Hold req high on a throughput instance and measure busy runs and done gaps.
  task automatic tput(input bit use15);
    int lat, run, ndone, last;
    logic r, d;
    lat = use15 ? 15 : 0;
    run = 0; ndone = 0; last = -1;
    if (use15) req_l15 = 1'b1; else req_l0 = 1'b1;
    for (int i = 0; i < 4 * (lat + 2); i++) begin
      @(negedge clk);
      r = use15 ? rdy_l15 : rdy_l0;
      d = use15 ? done_l15 : done_l0;
      if (!r) run++;
      else if (run > 0) begin
        chk($sformatf("tput%0d_busy_len", lat), 32'(run), 32'(lat + 1));
        run = 0;
      end
      if (d) begin
        if (last >= 0) chk($sformatf("tput%0d_gap", lat), 32'(i - last), 32'(lat + 2));
        last = i;
        ndone++;
      end
    end
    req_l0 = 1'b0; req_l15 = 1'b0;
    chk($sformatf("tput%0d_done_count", lat), 32'(ndone), 32'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone, first, nlow;
    reset_n = 1'b0;
    req = 1'b0; we = 1'b0; size = 2'b10; sgn = 1'b0; a = 32'h0; wd = 32'h0;
    req_l0 = 1'b0; req_l15 = 1'b0;

    //              we    size   sgn  addr          wdata         err   rd
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h14,  32'hABCD1234, 1'b0, 32'h00000000));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h14,  32'h0,        1'b0, 32'hABCD1234));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h17,  32'h0000009C, 1'b0, 32'hABCD1234));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h14,  32'h0,        1'b0, 32'h9CCD1234));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h17,  32'h0,        1'b0, 32'hFFFFFF9C));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h17,  32'h0,        1'b0, 32'h0000009C));
    vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h16,  32'h0,        1'b0, 32'hFFFF9CCD));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h10,  32'h55667788, 1'b0, 32'hFFFF9CCD));
    vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h12,  32'hAAAABEEF, 1'b0, 32'hFFFF9CCD));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        1'b0, 32'hBEEF7788));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h12,  32'h0,        1'b0, 32'h0000BEEF));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h10,  32'h0,        1'b0, 32'hFFFFFF88));
    vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h10,  32'h0,        1'b0, 32'h00007788));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h11,  32'h0,        1'b0, 32'h00000077));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h15,  32'h0,        1'b1, 32'h00000000));
    vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h11,  32'h00001234, 1'b1, 32'h00000000));
    vecs.push_back(mk(1'b1, 2'b11, 1'b0, 32'h10,  32'hFFFFFFFF, 1'b1, 32'h00000000));
    vecs.push_back(mk(1'b0, 2'b11, 1'b0, 32'h14,  32'h0,        1'b1, 32'h00000000));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h14,  32'h0,        1'b0, 32'h9CCD1234));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        1'b0, 32'hBEEF7788));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h00,  32'h01020304, 1'b0, 32'hBEEF7788));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 1'b1, 32'h00000000));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'hFC,  32'hCAFEF00D, 1'b0, 32'h00000000));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'hFC,  32'h0,        1'b0, 32'hCAFEF00D));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h00,  32'h0,        1'b0, 32'h01020304));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h104, 32'h0,        1'b1, 32'h00000000));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h20,  32'h77777777, 1'b0, 32'h00000000));

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", {28'h0, ready, done, err, 1'b0}, {28'h0, 4'b1000});
    chk("reset_rd", rd, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", 32'(ready), 32'd1);

    foreach (vecs[i]) do_access($sformatf("vec%0d", i), vecs[i]);

    // Reset during BUSY of a store: no write, no done, outputs cleared at once
    req = 1'b1; we = 1'b1; size = 2'b10; sgn = 1'b0; a = 32'h20; wd = 32'h11111111;
    @(negedge clk);
    req = 1'b0;
    chk("rst_mid_busy", 32'(ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {28'h0, ready, done, err, 1'b0}, {28'h0, 4'b1000});
    chk("rst_mid_rd", rd, 32'h0);
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("rst_mid_no_done", 32'(ndone), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    do_access("rst_mid_readback", mk(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h77777777));

    // Back-to-back throughput
    tput(1'b0);
    tput(1'b1);

    // LATENCY=15: request pulses during BUSY must be ignored
    @(negedge clk);
    req_l15 = 1'b1;
    ndone = 0; first = -1; nlow = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_l15) begin
        ndone++;
        if (first < 0) first = i;
      end
      if (!rdy_l15) nlow++;
      req_l15 = (i == 3 || i == 7 || i == 11) ? 1'b1 : 1'b0;
    end
    chk("busy_ignore_done_count", 32'(ndone), 32'd1);
    chk("busy_ignore_done_at", 32'(first), 32'd16);
    chk("busy_ignore_ready_low", 32'(nlow), 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
